// File: rtl/mem_pkg.sv
// Shared definitions for the word-memory bus clients (reader and writer side).
package mem_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_LEN_W  = 8;

  typedef logic [MEM_DATA_W-1:0] mem_word_t;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_WAIT_GRANT,
    RD_PRE_READ,
    RD_READ,
    RD_POST_READ,
    RD_DRAIN,
    RD_DONE
  } rd_state_e;

endpackage

// File: rtl/mem_rd_fifo2.sv
// Two-entry first-word-fall-through FIFO; the head register keeps the last
// popped word when the FIFO runs empty.
module mem_rd_fifo2
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic [1:0]        count_q;
  logic              pop_ok;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign head_o  = head_q;
  assign count_o = count_q;
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

  // NOTE: sequential state uses non-blocking assignments so every update
  // below sees the pre-edge values of head_q/tail_q/count_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      count_q <= 2'd0;
    end else begin
      unique case (count_q)
        2'd0: begin
          if (push_i) begin
            head_q  <= push_data_i;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push_i && pop_ok) begin
            head_q <= push_data_i;
          end else if (push_i) begin
            count_q <= 2'd2;
          end else if (pop_ok) begin
            count_q <= 2'd0;
          end
        end
        default: begin
          if (pop_ok) begin
            head_q  <= tail_q;
            count_q <= push_i ? 2'd2 : 2'd1;
          end
        end
      endcase
    end
  end

  // NOTE: tail_q is only read while count_q says it holds a word, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (push_i && (((count_q == 2'd1) && !pop_ok) || ((count_q == 2'd2) && pop_ok))) begin
      tail_q <= push_data_i;
    end
  end

endmodule

// File: rtl/memory_reader.sv
// Burst read engine: arbitrates once per word, runs the busy-based read
// handshake and returns words through a 2-entry valid/ready buffer.
module memory_reader
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int LEN_W  = MEM_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctl_request,
  input  logic [ADDR_W-1:0] ctl_addr,
  input  logic [LEN_W-1:0]  ctl_len,
  output logic              ctl_busy,
  output logic              ctl_done,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              arb_request,
  input  logic              arb_grant,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_rd_enable,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_busy
);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              bus_own;
  logic              rd_en;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RD_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    arb_request = 1'b0;
    bus_own     = 1'b0;
    rd_en       = 1'b0;
    push        = 1'b0;
    ctl_done    = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (ctl_request) begin
          if (ctl_len != '0) begin
            addr_d      = ctl_addr;
            remaining_d = ctl_len;
            state_d     = RD_WAIT_GRANT;
          end else begin
            state_d = RD_DONE;
          end
        end
      end
      RD_WAIT_GRANT: begin
        arb_request = 1'b1;
        if (arb_grant) state_d = RD_PRE_READ;
      end
      RD_PRE_READ: begin
        arb_request = 1'b1;
        bus_own     = 1'b1;
        rd_en       = 1'b1;
        if (mem_busy) state_d = RD_READ;
      end
      RD_READ: begin
        arb_request = 1'b1;
        bus_own     = 1'b1;
        if (!mem_busy) begin
          push        = 1'b1;
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          state_d     = RD_POST_READ;
        end
      end
      RD_POST_READ: begin
        // Arbiter is released here for at least one cycle per word.
        if (remaining_q == '0) begin
          state_d = RD_DRAIN;
        end else if (!fifo_full) begin
          state_d = RD_WAIT_GRANT;
        end
      end
      RD_DRAIN: begin
        if (fifo_empty) state_d = RD_DONE;
      end
      RD_DONE: begin
        ctl_done = 1'b1;
        state_d  = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign ctl_busy      = (state_q != RD_IDLE);
  assign out_valid     = (fifo_count != 2'd0);
  assign mem_rd_addr   = bus_own ? addr_q : 'z;
  assign mem_rd_enable = bus_own ? rd_en : 1'bz;

  mem_rd_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(mem_rd_data),
    .pop_i      (out_ready),
    .head_o     (out_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

endmodule

// File: tb/tb_memory_reader.sv
// Bench for memory_reader: memory/arbiter responder, transaction-level
// scoreboard checked every cycle, plus directed and randomized bursts.
module tb_memory_reader;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ctl_request;
  logic [AW-1:0] ctl_addr;
  logic [LW-1:0] ctl_len;
  logic          out_ready;
  logic          arb_grant;
  logic [DW-1:0] mem_rd_data;
  logic          mem_busy;
  wire           ctl_busy;
  wire           ctl_done;
  wire           out_valid;
  wire           arb_request;
  wire  [DW-1:0] out_data;
  // A released bus reads as all-ones address and a low strobe.
  tri1  [AW-1:0] mem_rd_addr;
  tri0           mem_rd_enable;

  memory_reader dut (
    .clk          (clk),
    .rst          (rst),
    .ctl_request  (ctl_request),
    .ctl_addr     (ctl_addr),
    .ctl_len      (ctl_len),
    .ctl_busy     (ctl_busy),
    .ctl_done     (ctl_done),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .arb_request  (arb_request),
    .arb_grant    (arb_grant),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_enable(mem_rd_enable),
    .mem_rd_data  (mem_rd_data),
    .mem_busy     (mem_busy)
  );

  always #5 clk = ~clk;

  // Memory controller and arbiter models.
  logic [DW-1:0] mem [0:65535];
  logic [AW-1:0] lat_addr = '0;
  int            busy_len;
  int            busy_cnt;
  int            ready_mode;
  int            grant_mode;
  logic          grant_ok;

  assign arb_grant   = arb_request && grant_ok;
  assign mem_busy    = (mem_rd_enable === 1'b1) || (busy_cnt != 0);
  assign mem_rd_data = mem[lat_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= 0;
    end else if (mem_rd_enable === 1'b1 && busy_cnt == 0) begin
      lat_addr <= mem_rd_addr;
      busy_cnt <= busy_len - 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
    grant_ok  = (grant_mode == 2) ? ($urandom_range(0, 2) != 0) : (grant_mode == 1);
  end

  // Scoreboard state.
  int            n_checks = 0;
  int            n_errors = 0;
  int            ncyc = 0;
  bit            active = 1'b0;
  bit            owned = 1'b0;
  int            cur_len = 0;
  int            n_strobe = 0;
  int            n_pop = 0;
  int            req_cyc = 0;
  int            last_pop_cyc = 0;
  int            first_valid_cyc = -1;
  int            done_cyc = 0;
  int            done_cnt = 0;
  logic [DW-1:0] exp_data [$];
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] popped [$];
  logic [AW-1:0] strobes [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit was_active;
    bit own_next;
    ncyc++;
    if (rst) begin
      active = 1'b0;
      owned  = 1'b0;
      exp_data.delete();
      exp_addr.delete();
    end else begin
      was_active = active;
      check("ctl_busy", 32'(ctl_busy), 32'(active));
      if (!active || cur_len == 0) check("arb_request_idle", 32'(arb_request), 32'd0);
      if (!active) check("done_idle", 32'(ctl_done), 32'd0);
      if (!owned) begin
        check("bus_addr_released", 32'(mem_rd_addr), 32'hFFFF);
        check("bus_en_released", 32'(mem_rd_enable), 32'd0);
      end
      if (mem_rd_enable === 1'b1 && mem_busy) begin
        check("strobe_owned", 32'(owned), 32'd1);
        if (exp_addr.size() != 0) check("strobe_addr", 32'(mem_rd_addr), 32'(exp_addr.pop_front()));
        else check("strobe_pending", 32'(exp_addr.size()), 32'd1);
        strobes.push_back(mem_rd_addr);
        n_strobe++;
      end
      own_next = arb_request && (owned ? !(mem_rd_enable !== 1'b1 && !mem_busy) : arb_grant);
      owned = own_next;
      if (active && out_valid && first_valid_cyc < 0) first_valid_cyc = ncyc;
      if (out_valid && out_ready) begin
        if (exp_data.size() != 0) check("pop_data", 32'(out_data), 32'(exp_data.pop_front()));
        else check("pop_pending", 32'(exp_data.size()), 32'd1);
        popped.push_back(out_data);
        n_pop++;
        last_pop_cyc = ncyc;
      end
      if (ctl_done && active) begin
        done_cyc = ncyc;
        done_cnt++;
        check("done_pops", 32'(n_pop), 32'(cur_len));
        check("done_strobes", 32'(n_strobe), 32'(cur_len));
        if (cur_len == 0) check("done_latency_zero", 32'((ncyc - req_cyc) inside {1, 2}), 32'd1);
        else check("done_after_pop", 32'(ncyc - last_pop_cyc), 32'd2);
        active = 1'b0;
      end
      if (ctl_request && !was_active) begin
        active          = 1'b1;
        cur_len         = int'(ctl_len);
        n_strobe        = 0;
        n_pop           = 0;
        req_cyc         = ncyc;
        first_valid_cyc = -1;
        exp_data.delete();
        exp_addr.delete();
        popped.delete();
        strobes.delete();
        for (int k = 0; k < cur_len; k++) begin
          exp_addr.push_back(ctl_addr + AW'(k));
          exp_data.push_back(mem[ctl_addr + AW'(k)]);
        end
      end
    end
  end

  task automatic start_burst(input logic [AW-1:0] a, input logic [LW-1:0] l);
    @(posedge clk);
    #1;
    ctl_request = 1'b1;
    ctl_addr    = a;
    ctl_len     = l;
    @(posedge clk);
    #1;
    ctl_request = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt >= target) break;
      @(posedge clk);
    end
    check("done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic run_burst(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int tgt;
    tgt = done_cnt + 1;
    start_burst(a, l);
    wait_done(tgt);
  endtask

  initial begin
    logic [DW-1:0] bp_exp [4];
    logic [AW-1:0] ra;
    logic [LW-1:0] rl;
    int            tgt;
    int            d0;
    bit            found;

    rst = 1'b1;
    ctl_request = 1'b0;
    ctl_addr = '0;
    ctl_len = '0;
    ready_mode = 1;
    grant_mode = 1;
    busy_len = 1;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503) ^ 16'h5A5A;

    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", 32'(ctl_busy), 32'd0);
    check("rst_done", 32'(ctl_done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_arb", 32'(arb_request), 32'd0);
    check("rst_bus_addr", 32'(mem_rd_addr), 32'hFFFF);
    check("rst_bus_en", 32'(mem_rd_enable), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Single word, immediate grant, one busy cycle.
    mem[16'h0010] = 16'hA5A5;
    run_burst(16'h0010, 8'd1);
    check("single_count", 32'(popped.size()), 32'd1);
    if (popped.size() >= 1) check("single_data", 32'(popped[0]), 32'hA5A5);
    if (strobes.size() >= 1) check("single_addr", 32'(strobes[0]), 32'h0010);
    check("single_valid_latency", 32'(first_valid_cyc - req_cyc), 32'd4);
    check("single_done_latency", 32'(done_cyc - last_pop_cyc), 32'd2);

    // Burst of 4 with the consumer stalled until the buffer fills.
    bp_exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int k = 0; k < 4; k++) mem[16'h0100 + k] = bp_exp[k];
    ready_mode = 0;
    tgt = done_cnt + 1;
    start_burst(16'h0100, 8'd4);
    for (int i = 0; i < 200 && n_strobe < 2; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    #2;
    check("stall_arb", 32'(arb_request), 32'd0);
    check("stall_bus_addr", 32'(mem_rd_addr), 32'hFFFF);
    check("stall_bus_en", 32'(mem_rd_enable), 32'd0);
    check("stall_reads", 32'(n_strobe), 32'd2);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_head", 32'(out_data), 32'h1111);
    ready_mode = 1;
    wait_done(tgt);
    check("bp_count", 32'(popped.size()), 32'd4);
    for (int k = 0; k < 4 && k < popped.size(); k++) check("bp_order", 32'(popped[k]), 32'(bp_exp[k]));

    // Address wrap.
    mem[16'hFFFF] = 16'hBEEF;
    mem[16'h0000] = 16'hCAFE;
    run_burst(16'hFFFF, 8'd2);
    if (strobes.size() >= 2) begin
      check("wrap_addr0", 32'(strobes[0]), 32'hFFFF);
      check("wrap_addr1", 32'(strobes[1]), 32'h0000);
    end
    if (popped.size() >= 2) begin
      check("wrap_data0", 32'(popped[0]), 32'hBEEF);
      check("wrap_data1", 32'(popped[1]), 32'hCAFE);
    end

    // Zero length: no memory access at all.
    run_burst(16'h1234, 8'd0);
    check("zero_reads", 32'(n_strobe), 32'd0);

    // Grant withheld for 10 cycles while another master owns the bus.
    grant_mode = 0;
    mem[16'h0500] = 16'h0F0F;
    tgt = done_cnt + 1;
    start_burst(16'h0500, 8'd1);
    for (int i = 0; i < 50 && !arb_request; i++) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      check("arb_hold_req", 32'(arb_request), 32'd1);
      check("arb_hold_en", 32'(mem_rd_enable), 32'd0);
      check("arb_hold_addr", 32'(mem_rd_addr), 32'hFFFF);
    end
    grant_mode = 1;
    wait_done(tgt);
    if (popped.size() >= 1) check("arb_data", 32'(popped[0]), 32'h0F0F);

    // Reset during the read of word 2 of 3.
    busy_len = 3;
    d0 = done_cnt;
    start_burst(16'h0200, 8'd3);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if (n_strobe == 2 && arb_request && mem_rd_enable === 1'b0 && mem_busy) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_reach_read2", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(ctl_busy), 32'd0);
    check("mid_rst_done", 32'(ctl_done), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_arb", 32'(arb_request), 32'd0);
    check("mid_rst_bus_addr", 32'(mem_rd_addr), 32'hFFFF);
    check("mid_rst_bus_en", 32'(mem_rd_enable), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    busy_len = 1;
    repeat (3) @(posedge clk);
    check("mid_no_done", 32'(done_cnt), 32'(d0));
    mem[16'h0300] = 16'h7E57;
    run_burst(16'h0300, 8'd1);
    check("mid_after_done", 32'(done_cnt), 32'(d0 + 1));
    if (popped.size() >= 1) check("mid_after_data", 32'(popped[0]), 32'h7E57);

    // Randomized bursts with random grant, ready and memory latency.
    ready_mode = 2;
    grant_mode = 2;
    for (int b = 0; b < 40; b++) begin
      busy_len = $urandom_range(1, 3);
      ra = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFC + $urandom_range(0, 3)) : AW'($urandom);
      rl = LW'($urandom_range(0, 6));
      tgt = done_cnt + 1;
      start_burst(ra, rl);
      if (rl >= 2 && $urandom_range(0, 1) == 1) begin
        repeat (2) @(posedge clk);
        #1;
        ctl_request = 1'b1;
        ctl_addr    = ~ra;
        ctl_len     = 8'd5;
        @(posedge clk);
        #1;
        ctl_request = 1'b0;
      end
      wait_done(tgt);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
